pixel_gen_multi: RTL and testbench

Parametrised, pipelined successor to the single-frame pixel generator. It renders a bird sprite, NUM_PIPES pipe pairs and a background colour for the VGA scan. Sprite positions are latched once per frame so updates never tear mid-frame. It also detects bird/pipe and bird/floor collisions in hardware and runs an IDLE/RUN/HIT display state machine, with the bird flashing while in HIT. It sits between the game-logic position registers and the VGA RGB pins, alongside the sync generator.

---
 rtl/pixel_gen_multi_if.sv | 33 +++
 rtl/pixel_gen_multi.sv | 203 ++++++++++++++++++++
 tb/tb_pixel_gen_multi.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_gen_multi_if.sv
// Pixel-side bus of pixel_gen_multi: scan position, sprite positions, game
// control in; registered colour and collision status out.
interface pixel_gen_multi_if #(
   parameter int NUM_PIPES = 3
);
   logic                      start;
   logic                      frame_start;
   logic                      video_on;
   logic [9:0]                pixel_x;
   logic [9:0]                pixel_y;
   logic [9:0]                bird_x;
   logic [9:0]                bird_y;
   logic [10*NUM_PIPES-1:0]   pipe_x;
   logic [10*NUM_PIPES-1:0]   pipe_y_up;
   logic [NUM_PIPES-1:0]      pipe_en;
   logic [3:0]                red;
   logic [3:0]                green;
   logic [3:0]                blue;
   logic                      collision;
   logic                      hit_pulse;

   modport master (
      output start, frame_start, video_on, pixel_x, pixel_y,
             bird_x, bird_y, pipe_x, pipe_y_up, pipe_en,
      input  red, green, blue, collision, hit_pulse
   );

   modport slave (
      input  start, frame_start, video_on, pixel_x, pixel_y,
             bird_x, bird_y, pipe_x, pipe_y_up, pipe_en,
      output red, green, blue, collision, hit_pulse
   );
endinterface

// File: rtl/pixel_gen_multi.sv
// Two-stage pixel generator: bird sprite, NUM_PIPES pipe pairs and background,
// with per-frame shadowed positions, collision detection and IDLE/RUN/HIT FSM.
module pixel_gen_multi #(
   parameter int          NUM_PIPES    = 3,
   parameter int          PIPE_W       = 40,
   parameter int          GAP_H        = 80,
   parameter int          BIRD_SIZE    = 20,
   parameter int          H_RES        = 640,
   parameter int          V_RES        = 480,
   parameter int          FLASH_FRAMES = 8,
   parameter logic [11:0] BIRD_RGB     = 12'hF00,
   parameter logic [11:0] PIPE_RGB     = 12'h0F0,
   parameter logic [11:0] BG_RGB       = 12'h000
) (
   input  logic              clk_div,
   input  logic              rst_n,
   pixel_gen_multi_if.slave  bus
);

   if (NUM_PIPES < 1 || NUM_PIPES > 8 || H_RES < 1 || H_RES > 1024 ||
       V_RES < 1 || V_RES > 1024 || FLASH_FRAMES < 1) begin : g_param_check
      $error("pixel_gen_multi: parameter out of range");
   end

   localparam logic [10:0] BIRD11  = 11'(BIRD_SIZE);
   localparam logic [10:0] PIPEW11 = 11'(PIPE_W);
   localparam logic [10:0] GAP11   = 11'(GAP_H);
   localparam logic [10:0] VRES11  = 11'(V_RES);
   localparam int          FCW     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_FRAMES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HIT} state_e;

   // Shadow copies of the sprite positions
   logic [9:0]              bx_q, bx_d, by_q, by_d;
   logic [10*NUM_PIPES-1:0] px_q, px_d, pyu_q, pyu_d;
   logic [NUM_PIPES-1:0]    pen_q, pen_d;

   // Pipeline
   logic                    bird_hit_q, bird_hit_d;
   logic [NUM_PIPES-1:0]    pipe_hit_q, pipe_hit_d;
   logic                    von1_q, von1_d;
   logic [11:0]             rgb_q, rgb_d;

   // Control
   state_e                  state_q, state_d;
   logic                    coll_frame_q, coll_frame_d;
   logic [FCW-1:0]          flash_q, flash_d;
   logic                    bird_vis_q, bird_vis_d;
   logic                    hit_pulse_q, hit_pulse_d;

   logic [10:0]             x11, y11, bx11, by11, px11, py11;
   logic                    any_pipe, floor_hit, coll_set;

   always_comb begin
      bx_d  = bx_q;
      by_d  = by_q;
      px_d  = px_q;
      pyu_d = pyu_q;
      pen_d = pen_q;
      if (bus.frame_start) begin
         bx_d  = bus.bird_x;
         by_d  = bus.bird_y;
         px_d  = bus.pipe_x;
         pyu_d = bus.pipe_y_up;
         pen_d = bus.pipe_en;
      end
   end

   // Stage 1: per-object hit tests; all bound sums carried in 11 bits
   always_comb begin
      x11  = {1'b0, bus.pixel_x};
      y11  = {1'b0, bus.pixel_y};
      bx11 = {1'b0, bx_q};
      by11 = {1'b0, by_q};
      px11 = '0;
      py11 = '0;
      bird_hit_d = (x11 >= bx11) && (x11 < bx11 + BIRD11) &&
                   (y11 >= by11) && (y11 < by11 + BIRD11);
      pipe_hit_d = '0;
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
         px11 = {1'b0, px_q[10*i +: 10]};
         py11 = {1'b0, pyu_q[10*i +: 10]};
         pipe_hit_d[i] = pen_q[i] && (x11 >= px11) && (x11 < px11 + PIPEW11) &&
                         ((y11 < py11) || ((y11 >= py11 + GAP11) && (y11 < VRES11)));
      end
      von1_d = bus.video_on;
   end

   // Stage 2: colour priority bird > pipe > background
   always_comb begin
      any_pipe = |pipe_hit_q;
      rgb_d    = '0;
      if (von1_q) begin
         rgb_d = BG_RGB;
         if (state_q != ST_IDLE) begin
            if (bird_hit_q && bird_vis_q) begin
               rgb_d = BIRD_RGB;
            end else if (any_pipe) begin
               rgb_d = PIPE_RGB;
            end
         end
      end
   end

   // Clear on frame_start, but a same-cycle set still lands
   always_comb begin
      floor_hit    = (by11 + BIRD11) > VRES11;
      coll_set     = (state_q == ST_RUN) &&
                     ((von1_q && bird_hit_q && any_pipe) || floor_hit);
      coll_frame_d = coll_frame_q;
      if (bus.frame_start) begin
         coll_frame_d = 1'b0;
      end
      if (coll_set) begin
         coll_frame_d = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      hit_pulse_d = 1'b0;
      flash_d     = flash_q;
      bird_vis_d  = bird_vis_q;
      if (bus.frame_start) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (coll_frame_q) begin
                  state_d     = ST_HIT;
                  hit_pulse_d = 1'b1;
                  flash_d     = '0;
                  bird_vis_d  = 1'b1;
               end else if (!bus.start) begin
                  state_d = ST_IDLE;
               end
            end
            ST_HIT: begin
               if (!bus.start) begin
                  state_d    = ST_IDLE;
                  flash_d    = '0;
                  bird_vis_d = 1'b1;
               end else if (flash_q == FLASH_LAST) begin
                  flash_d    = '0;
                  bird_vis_d = !bird_vis_q;
               end else begin
                  flash_d = flash_q + 1'b1;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               flash_d    = '0;
               bird_vis_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_div or negedge rst_n) begin
      if (!rst_n) begin
         bx_q         <= '0;
         by_q         <= '0;
         px_q         <= '0;
         pyu_q        <= '0;
         pen_q        <= '0;
         bird_hit_q   <= 1'b0;
         pipe_hit_q   <= '0;
         von1_q       <= 1'b0;
         rgb_q        <= '0;
         state_q      <= ST_IDLE;
         coll_frame_q <= 1'b0;
         flash_q      <= '0;
         bird_vis_q   <= 1'b1;
         hit_pulse_q  <= 1'b0;
      end else begin
         bx_q         <= bx_d;
         by_q         <= by_d;
         px_q         <= px_d;
         pyu_q        <= pyu_d;
         pen_q        <= pen_d;
         bird_hit_q   <= bird_hit_d;
         pipe_hit_q   <= pipe_hit_d;
         von1_q       <= von1_d;
         rgb_q        <= rgb_d;
         state_q      <= state_d;
         coll_frame_q <= coll_frame_d;
         flash_q      <= flash_d;
         bird_vis_q   <= bird_vis_d;
         hit_pulse_q  <= hit_pulse_d;
      end
   end

   assign bus.red       = rgb_q[11:8];
   assign bus.green     = rgb_q[7:4];
   assign bus.blue      = rgb_q[3:0];
   assign bus.collision = (state_q == ST_HIT);
   assign bus.hit_pulse = hit_pulse_q;

endmodule

// File: tb/tb_pixel_gen_multi.sv
// Directed scoreboard bench for pixel_gen_multi: drawing, tearing, collision,
// flash, edge cases and asynchronous reset.
module tb_pixel_gen_multi;
   localparam int NP = 3;

   logic clk_div = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_div = ~clk_div;

   pixel_gen_multi_if #(.NUM_PIPES(NP)) bus();

   pixel_gen_multi #(.NUM_PIPES(NP)) dut (
      .clk_div (clk_div),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   typedef struct {
      string       name;
      logic [11:0] rgb;
      logic        coll;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   n_vec    = 0;
   int   n_err    = 0;
   int   hit_seen = 0;
   logic chk = 1'b0, chk_d1 = 1'b0, chk_d2 = 1'b0;

   // Bench-side tag matching the two-cycle pixel latency
   always @(posedge clk_div) begin
      chk_d1 <= chk;
      chk_d2 <= chk_d1;
   end

   always @(negedge clk_div) begin
      if (bus.hit_pulse === 1'b1) hit_seen++;
      if (chk_d2) begin
         n_vec++;
         if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: output present with no expected entry");
         end else begin
            e = sbq.pop_front();
            if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.collision !== e.coll) begin
               n_err++;
               $display("FAIL %s: got rgb=%h coll=%b, want rgb=%h coll=%b", e.name,
                        {bus.red, bus.green, bus.blue}, bus.collision, e.rgb, e.coll);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic pix(input int x, input int y, input logic von,
                      input logic [11:0] rgb, input logic coll, input string name);
      exp_t t;
      bus.pixel_x  = 10'(x);
      bus.pixel_y  = 10'(y);
      bus.video_on = von;
      t.name = name;
      t.rgb  = rgb;
      t.coll = coll;
      sbq.push_back(t);
      chk = 1'b1;
      @(negedge clk_div);
      chk = 1'b0;
   endtask

   task automatic frame(input logic st);
      bus.video_on = 1'b0;
      chk = 1'b0;
      repeat (3) @(negedge clk_div);
      bus.start       = st;
      bus.frame_start = 1'b1;
      @(negedge clk_div);
      bus.frame_start = 1'b0;
   endtask

   task automatic set_pipe(input int i, input int x, input int y);
      bus.pipe_x[10*i +: 10]    = 10'(x);
      bus.pipe_y_up[10*i +: 10] = 10'(y);
   endtask

   task automatic set_bird(input int x, input int y);
      bus.bird_x = 10'(x);
      bus.bird_y = 10'(y);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.frame_start = 1'b0; bus.video_on = 1'b0;
      bus.pixel_x = '0; bus.pixel_y = '0; bus.bird_x = '0; bus.bird_y = '0;
      bus.pipe_x = '0; bus.pipe_y_up = '0; bus.pipe_en = '0;

      repeat (3) @(negedge clk_div);
      check("rst_rgb",  32'({bus.red, bus.green, bus.blue}), 32'h0);
      check("rst_coll", 32'(bus.collision), 32'h0);
      check("rst_hit",  32'(bus.hit_pulse), 32'h0);
      rst_n = 1'b1;
      @(negedge clk_div);

      // IDLE: background only, shadowed bird at (0,0) not drawn
      frame(1'b0);
      pix(100, 100, 1'b1, 12'h000, 1'b0, "idle_bg");
      pix(5, 5, 1'b1, 12'h000, 1'b0, "idle_no_bird");

      set_bird(50, 200);
      set_pipe(0, 300, 150);
      set_pipe(1, 1010, 100);
      set_pipe(2, 500, 420);
      bus.pipe_en = 3'b001;
      frame(1'b1);
      pix(55, 205, 1'b1, 12'hF00, 1'b0, "draw_bird");
      pix(310, 100, 1'b1, 12'h0F0, 1'b0, "draw_pipe_up");
      pix(310, 200, 1'b1, 12'h000, 1'b0, "draw_gap");
      pix(310, 229, 1'b1, 12'h000, 1'b0, "draw_gap_last");
      pix(310, 230, 1'b1, 12'h0F0, 1'b0, "draw_pipe_low");
      pix(69, 219, 1'b1, 12'hF00, 1'b0, "bird_edge_in");
      pix(70, 219, 1'b1, 12'h000, 1'b0, "bird_edge_x_out");
      pix(69, 220, 1'b1, 12'h000, 1'b0, "bird_edge_y_out");
      pix(50, 200, 1'b1, 12'hF00, 1'b0, "bird_corner");
      pix(49, 200, 1'b1, 12'h000, 1'b0, "bird_left_out");
      pix(300, 149, 1'b1, 12'h0F0, 1'b0, "pipe_corner");
      pix(299, 149, 1'b1, 12'h000, 1'b0, "pipe_left_out");
      pix(340, 10, 1'b1, 12'h000, 1'b0, "pipe_right_out");
      pix(55, 205, 1'b0, 12'h000, 1'b0, "blank_video_off");
      pix(1015, 10, 1'b1, 12'h000, 1'b0, "pipe1_disabled");

      bus.pipe_en = 3'b111;
      frame(1'b1);
      pix(1015, 10, 1'b1, 12'h0F0, 1'b0, "pipe1_high_x");
      pix(5, 10, 1'b1, 12'h000, 1'b0, "no_wrap_x5");
      pix(29, 10, 1'b1, 12'h000, 1'b0, "no_wrap_x29");
      pix(510, 419, 1'b1, 12'h0F0, 1'b0, "pipe2_upper");
      pix(510, 420, 1'b1, 12'h000, 1'b0, "pipe2_gap");
      pix(510, 479, 1'b1, 12'h000, 1'b0, "pipe2_no_lower");

      // Tearing: mid-frame change must not show until next frame_start
      set_bird(100, 200);
      pix(55, 205, 1'b1, 12'hF00, 1'b0, "tear_old_pos");
      pix(105, 205, 1'b1, 12'h000, 1'b0, "tear_new_hidden");
      frame(1'b1);
      pix(105, 205, 1'b1, 12'hF00, 1'b0, "tear_new_pos");
      pix(55, 205, 1'b1, 12'h000, 1'b0, "tear_old_gone");

      // Disabled pipe under the bird: no collision
      set_bird(300, 100);
      bus.pipe_en = 3'b110;
      frame(1'b1);
      pix(305, 105, 1'b1, 12'hF00, 1'b0, "dis_overlap");
      bus.pipe_en = 3'b111;
      frame(1'b1);
      check("dis_no_hit_pulse", 32'(bus.hit_pulse), 32'h0);
      pix(305, 105, 1'b1, 12'hF00, 1'b0, "overlap_run");
      frame(1'b1);
      check("hit_pulse_on", 32'(bus.hit_pulse), 32'h1);
      check("collision_on", 32'(bus.collision), 32'h1);
      @(negedge clk_div);
      check("hit_pulse_off", 32'(bus.hit_pulse), 32'h0);
      pix(305, 105, 1'b1, 12'hF00, 1'b1, "hit_bird_vis");
      pix(310, 50, 1'b1, 12'h0F0, 1'b1, "hit_pipe");

      for (int k = 1; k <= 16; k++) begin
         frame(1'b1);
         if (k == 7)  pix(305, 105, 1'b1, 12'hF00, 1'b1, "flash_f7_vis");
         if (k == 8)  pix(305, 105, 1'b1, 12'h0F0, 1'b1, "flash_f8_hidden");
         if (k == 15) pix(305, 105, 1'b1, 12'h0F0, 1'b1, "flash_f15_hidden");
         if (k == 16) pix(305, 105, 1'b1, 12'hF00, 1'b1, "flash_f16_vis");
      end

      frame(1'b0);
      pix(305, 105, 1'b1, 12'h000, 1'b0, "hit_to_idle");

      // Floor: 465 + 20 > 480
      set_bird(100, 465);
      frame(1'b1);
      pix(105, 470, 1'b1, 12'hF00, 1'b0, "floor_run");
      frame(1'b1);
      check("floor_hit_pulse", 32'(bus.hit_pulse), 32'h1);
      pix(105, 470, 1'b1, 12'hF00, 1'b1, "floor_hit");

      // Asynchronous reset mid-frame while in HIT
      bus.pixel_x = 10'd105; bus.pixel_y = 10'd470; bus.video_on = 1'b1;
      repeat (3) @(negedge clk_div);
      check("pre_rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hF00);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rgb",  32'({bus.red, bus.green, bus.blue}), 32'h0);
      check("mid_rst_coll", 32'(bus.collision), 32'h0);
      check("mid_rst_hit",  32'(bus.hit_pulse), 32'h0);
      @(negedge clk_div);
      rst_n = 1'b1;
      @(negedge clk_div);
      pix(105, 470, 1'b1, 12'h000, 1'b0, "post_rst_idle");
      pix(5, 5, 1'b1, 12'h000, 1'b0, "post_rst_no_bird");

      bus.video_on = 1'b0;
      for (int w = 0; w < 10 && sbq.size() != 0; w++) @(negedge clk_div);
      if (sbq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_drain: %0d entries left, want 0", sbq.size());
      end
      check("hit_pulse_count", 32'(hit_seen), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
